// File: rtl/osd_cmd_arbiter.sv
// ---------------------------------------------------------------------------
// osd_cmd_arbiter
//
// Purpose:
//   Arbitrates two byte-stream packet sources onto the single command-byte
//   input of an on-screen-display engine. A packet is owned from its first
//   byte to its last byte. Simultaneous packet starts are resolved
//   round-robin. Every packet is followed by one dead (GAP) cycle.
//   Forwarded bytes appear one cycle after they are accepted.
//
// Optional feature (macro OSD_ARB_TIMEOUT_EN):
//   When defined, an owner that stalls for TIMEOUT consecutive granted
//   cycles loses the grant. The packet is abandoned and abort_cnt counts
//   the event, saturating at 255. When undefined, a grant is held until
//   the last byte and abort_cnt is tied to 0.
//
// Parameters:
//   TIMEOUT     idle granted cycles before the grant is revoked (1..255)
//
// Ports:
//   clk                       sole clock
//   reset                     synchronous, active-high reset
//   reqN_valid/first/last     byte present / first byte / last byte (N=0,1)
//   reqN_data[7:0]            packet byte
//   reqN_ready                byte taken this cycle when reqN_valid is high
//   out_strobe                one-cycle strobe per forwarded byte
//   out_start                 forwarded byte is a command (first) byte
//   out_data[7:0]             forwarded byte
//   grant[1:0]                one-hot current owner, 00 when none
//   abort_cnt[7:0]            saturating count of timed-out packets
// ---------------------------------------------------------------------------
module osd_cmd_arbiter #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req0_valid,
    input  logic       req0_first,
    input  logic       req0_last,
    input  logic [7:0] req0_data,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic       req1_first,
    input  logic       req1_last,
    input  logic [7:0] req1_data,
    output logic       req1_ready,
    output logic       out_strobe,
    output logic       out_start,
    output logic [7:0] out_data,
    output logic [1:0] grant,
    output logic [7:0] abort_cnt
);

    if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
        $error("osd_cmd_arbiter: TIMEOUT must lie in 1..255");
    end

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_GRANT = 2'd1;
    localparam logic [1:0] ST_GAP   = 2'd2;

    logic [1:0] state_q, state_d;
    logic       owner_q, owner_d;     // 0: req0 owns, 1: req1 owns
    logic       rr_q, rr_d;           // requester that completed the latest packet
    logic       out_strobe_q, out_strobe_d;
    logic       out_start_q, out_start_d;
    logic [7:0] out_data_q, out_data_d;
    logic       rdy0, rdy1;

    // Owner-side view of the request lines.
    logic       sel_valid, sel_first, sel_last;
    logic [7:0] sel_data;
    logic       cand0, cand1;

    assign sel_valid = owner_q ? req1_valid : req0_valid;
    assign sel_first = owner_q ? req1_first : req0_first;
    assign sel_last  = owner_q ? req1_last  : req0_last;
    assign sel_data  = owner_q ? req1_data  : req0_data;

    assign cand0 = req0_valid & req0_first;
    assign cand1 = req1_valid & req1_first;

`ifdef OSD_ARB_TIMEOUT_EN
    localparam logic [7:0] TIMEOUT_C = TIMEOUT[7:0];

    logic [7:0] tmo_cnt_q, tmo_cnt_d;
    logic [7:0] abort_cnt_q, abort_cnt_d;
    logic [7:0] tmo_inc;

    assign tmo_inc = tmo_cnt_q + 8'd1;
`endif

    always_comb begin
        // NOTE: every signal assigned in this block gets a default first, so
        // no path leaves one unassigned and no latch is inferred.
        state_d      = state_q;
        owner_d      = owner_q;
        rr_d         = rr_q;
        out_strobe_d = 1'b0;
        out_start_d  = 1'b0;
        out_data_d   = 8'h00;
        rdy0         = 1'b0;
        rdy1         = 1'b0;
`ifdef OSD_ARB_TIMEOUT_EN
        tmo_cnt_d    = tmo_cnt_q;
        abort_cnt_d  = abort_cnt_q;
`endif

        case (state_q)
            ST_IDLE: begin
                // Mid-packet bytes seen while idle belong to no packet:
                // swallow them so the source resynchronises on a first byte.
                // A first byte is held back and taken in the GRANT cycle.
                rdy0 = req0_valid & ~req0_first;
                rdy1 = req1_valid & ~req1_first;
                if (cand0 | cand1) begin
                    state_d = ST_GRANT;
                    // On a tie, serve the requester that did not finish last.
                    owner_d = (cand0 & cand1) ? ~rr_q : cand1;
`ifdef OSD_ARB_TIMEOUT_EN
                    tmo_cnt_d = 8'h00;
`endif
                end
            end

            ST_GRANT: begin
                rdy0 = ~owner_q;
                rdy1 = owner_q;
                // The owner's ready is high throughout GRANT, so its valid
                // alone marks a transfer; a transfer always beats a timeout.
                if (sel_valid) begin
                    out_strobe_d = 1'b1;
                    out_start_d  = sel_first;
                    out_data_d   = sel_data;
`ifdef OSD_ARB_TIMEOUT_EN
                    tmo_cnt_d    = 8'h00;
`endif
                    if (sel_last) begin
                        state_d = ST_GAP;
                        rr_d    = owner_q;
                    end
                end
`ifdef OSD_ARB_TIMEOUT_EN
                else begin
                    tmo_cnt_d = tmo_inc;
                    if (tmo_inc == TIMEOUT_C) begin
                        state_d = ST_GAP;
                        if (abort_cnt_q != 8'hFF) begin
                            abort_cnt_d = abort_cnt_q + 8'd1;
                        end
                    end
                end
`endif
            end

            ST_GAP: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples the pre-edge values, independent of statement order.
        if (reset) begin
            state_q      <= ST_IDLE;
            owner_q      <= 1'b0;
            rr_q         <= 1'b1;   // req1 marked as last served: a tie favours req0
            out_strobe_q <= 1'b0;
            out_start_q  <= 1'b0;
            out_data_q   <= 8'h00;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            rr_q         <= rr_d;
            out_strobe_q <= out_strobe_d;
            out_start_q  <= out_start_d;
            out_data_q   <= out_data_d;
        end
    end

`ifdef OSD_ARB_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            tmo_cnt_q   <= 8'h00;
            abort_cnt_q <= 8'h00;
        end else begin
            tmo_cnt_q   <= tmo_cnt_d;
            abort_cnt_q <= abort_cnt_d;
        end
    end

    assign abort_cnt = reset ? 8'h00 : abort_cnt_q;
`else
    assign abort_cnt = 8'h00;
`endif

    // Reset is synchronous, so the registers still hold pre-reset values
    // during the first reset cycle. Masking the outputs makes the block
    // look idle for every cycle that reset is high, and suppresses the
    // strobe of a byte accepted just before reset.
    assign req0_ready = rdy0 & ~reset;
    assign req1_ready = rdy1 & ~reset;
    assign out_strobe = out_strobe_q & ~reset;
    assign out_start  = out_start_q & ~reset;
    assign out_data   = reset ? 8'h00 : out_data_q;
    assign grant      = (state_q == ST_GRANT && !reset) ? {owner_q, ~owner_q} : 2'b00;

endmodule
